// File: rtl/decimating_sample_feeder.sv
// decimating_sample_feeder
// Sums a free-running signed ADC stream in blocks of 2^k samples and hands one
// scaled sum per block to a downstream filter as a single-cycle strobe, honouring
// the filter's busy back-pressure and flagging dropped blocks.
// Optional feature macro: FEEDER_OVERRUN_CNT_EN adds a 16-bit saturating
// dropped-block counter on overrun_cnt_o.

module decimating_sample_feeder #(
    parameter int ADC_WIDTH      = 14,
    parameter int MAX_DECIM_LOG2 = 3,
    parameter int OUTPUT_WIDTH   = 17
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   enable_i,
    input  logic [$clog2(MAX_DECIM_LOG2+1)-1:0]    decim_log2_i,
    input  logic signed [ADC_WIDTH-1:0]            adc_i,
    input  logic                                   busy_i,
    input  logic                                   clear_i,
    output logic signed [OUTPUT_WIDTH-1:0]         data_o,
    output logic                                   data_valid_o,
    output logic                                   overrun_o
`ifdef FEEDER_OVERRUN_CNT_EN
    ,
    output logic [15:0]                            overrun_cnt_o
`endif
);

    localparam int KW = $clog2(MAX_DECIM_LOG2 + 1);
    localparam int PW = MAX_DECIM_LOG2;
    localparam int EW = OUTPUT_WIDTH - ADC_WIDTH;

    // Clamp a requested ratio to the largest supported one.
    function automatic logic [KW-1:0] sat_k(input logic [KW-1:0] k);
        if (k > KW'(MAX_DECIM_LOG2)) begin
            return KW'(MAX_DECIM_LOG2);
        end else begin
            return k;
        end
    endfunction

    // Phase value of the last sample in a block of 2^k samples.
    function automatic logic [PW-1:0] last_phase(input logic [KW-1:0] k);
        logic [PW:0] span;
        span = {{PW{1'b0}}, 1'b1} << k;
        return PW'(span - {{PW{1'b0}}, 1'b1});
    endfunction

    // State registers and their next-state values
    logic [PW-1:0]                  phase_cnt_q, phase_cnt_d;
    logic signed [OUTPUT_WIDTH-1:0] acc_q, acc_d;
    logic [KW-1:0]                  k_lat_q, k_lat_d;
    logic signed [OUTPUT_WIDTH-1:0] data_q, data_d;
    logic                           valid_q, valid_d;
    logic                           overrun_q, overrun_d;
`ifdef FEEDER_OVERRUN_CNT_EN
    logic [15:0]                    ovr_cnt_q, ovr_cnt_d;
`endif

    // Datapath helpers
    logic signed [OUTPUT_WIDTH-1:0] sample_ext_s;
    logic signed [OUTPUT_WIDTH-1:0] sum_s;
    logic signed [OUTPUT_WIDTH-1:0] cand_s;
    logic                           block_start_s;
    logic                           block_end_s;
    logic [KW-1:0]                  k_cur_s;
    logic [KW-1:0]                  shamt_s;
    logic                           drop_s;

    // Sample extension, running sum and block boundary detection.
    // At a block start the ratio for this block is the freshly sampled request,
    // so a k=0 block starts and ends in the same cycle.
    always_comb begin
        sample_ext_s  = {{EW{adc_i[ADC_WIDTH-1]}}, adc_i};
        block_start_s = (phase_cnt_q == {PW{1'b0}});
        if (block_start_s) begin
            k_cur_s = sat_k(decim_log2_i);
            sum_s   = sample_ext_s;
        end else begin
            k_cur_s = k_lat_q;
            sum_s   = acc_q + sample_ext_s;
        end
        block_end_s = (phase_cnt_q == last_phase(k_cur_s));
        shamt_s     = KW'(MAX_DECIM_LOG2) - k_cur_s;
        cand_s      = sum_s << shamt_s;
    end

    // Next-state logic for the accumulator, phase, output and status.
    always_comb begin
        phase_cnt_d = phase_cnt_q;
        acc_d       = acc_q;
        k_lat_d     = k_lat_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        drop_s      = 1'b0;

        if (!enable_i) begin
            // Idle: discard any partial block, no strobe.
            phase_cnt_d = {PW{1'b0}};
            acc_d       = {OUTPUT_WIDTH{1'b0}};
        end else begin
            k_lat_d = k_cur_s;
            acc_d   = sum_s;
            if (block_end_s) begin
                phase_cnt_d = {PW{1'b0}};
                if (!busy_i) begin
                    data_d  = cand_s;
                    valid_d = 1'b1;
                end else begin
                    drop_s  = 1'b1;
                end
            end else begin
                phase_cnt_d = phase_cnt_q + {{(PW-1){1'b0}}, 1'b1};
            end
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clear_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

`ifdef FEEDER_OVERRUN_CNT_EN
    // Saturating dropped-block counter; a simultaneous clear restarts it at one.
    always_comb begin
        if (drop_s) begin
            if (clear_i) begin
                ovr_cnt_d = 16'd1;
            end else if (ovr_cnt_q != 16'hFFFF) begin
                ovr_cnt_d = ovr_cnt_q + 16'd1;
            end else begin
                ovr_cnt_d = ovr_cnt_q;
            end
        end else if (clear_i) begin
            ovr_cnt_d = 16'd0;
        end else begin
            ovr_cnt_d = ovr_cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovr_cnt_q <= 16'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_cnt_q <= {PW{1'b0}};
            acc_q       <= {OUTPUT_WIDTH{1'b0}};
            k_lat_q     <= {KW{1'b0}};
            data_q      <= {OUTPUT_WIDTH{1'b0}};
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            acc_q       <= acc_d;
            k_lat_q     <= k_lat_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_decimating_sample_feeder.sv
// Self-checking bench for decimating_sample_feeder: directed scenarios followed
// by randomized traffic, all compared against a block-level reference model.

module tb_decimating_sample_feeder;

    localparam int AW = 14;
    localparam int MK = 3;
    localparam int OW = 17;
    localparam int KW = $clog2(MK + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [KW-1:0]        decim;
    logic signed [AW-1:0] adc;
    logic                 busy;
    logic                 clear;
    logic [OW-1:0]        data_o;
    logic                 data_valid_o;
    logic                 overrun_o;
`ifdef FEEDER_OVERRUN_CNT_EN
    logic [15:0]          overrun_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int            blk_q[$];
    int            blk_k;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ovr;
    int            m_cnt;

    always #5 clk = ~clk;

    decimating_sample_feeder #(
        .ADC_WIDTH(AW), .MAX_DECIM_LOG2(MK), .OUTPUT_WIDTH(OW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(enable),
        .decim_log2_i(decim),
        .adc_i(adc),
        .busy_i(busy),
        .clear_i(clear),
        .data_o(data_o),
        .data_valid_o(data_valid_o),
        .overrun_o(overrun_o)
`ifdef FEEDER_OVERRUN_CNT_EN
        ,
        .overrun_cnt_o(overrun_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Block-level model: collect samples of a block, sum them when the block is full.
    task automatic model_step();
        bit drop;
        int s;
        drop = 1'b0;
        if (rst) begin
            blk_q.delete();
            blk_k   = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_cnt   = 0;
        end else begin
            m_valid = 1'b0;
            if (!enable) begin
                blk_q.delete();
            end else begin
                if (blk_q.size() == 0) blk_k = (int'(decim) > MK) ? MK : int'(decim);
                blk_q.push_back(int'(adc));
                if (blk_q.size() == (1 << blk_k)) begin
                    s = 0;
                    foreach (blk_q[i]) s += blk_q[i];
                    s = s * (1 << (MK - blk_k));
                    if (!busy) begin
                        m_data  = OW'(s);
                        m_valid = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    blk_q.delete();
                end
            end
            if (drop) m_ovr = 1'b1;
            else if (clear) m_ovr = 1'b0;
            if (drop) m_cnt = clear ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
            else if (clear) m_cnt = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("data", 32'(data_o), 32'(m_data));
        check("valid", 32'(data_valid_o), 32'(m_valid));
        check("overrun", 32'(overrun_o), 32'(m_ovr));
`ifdef FEEDER_OVERRUN_CNT_EN
        check("ovr_cnt", 32'(overrun_cnt_o), 32'(m_cnt));
`endif
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; decim = '0; adc = '0; busy = 1'b0; clear = 1'b0;
        blk_k = 0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_cnt = 0;

        // Reset state
        repeat (3) cyc();
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(data_valid_o), 32'd0);
        rst = 1'b0;
        cyc();

        // k=3, constant 100: first strobe one cycle after the 8th sample
        decim = 2'd3; adc = 14'sd100; enable = 1'b1;
        repeat (7) cyc();
        check("k3_no_early", 32'(data_valid_o), 32'd0);
        cyc();
        check("k3_first_strobe", 32'(data_valid_o), 32'd1);
        check("k3_800", 32'(data_o), 32'd800);
        repeat (16) cyc();

        // k=0 extremes
        decim = 2'd0; adc = 14'sh2000;
        cyc();
        check("k0_min", 32'(data_o), 32'h10000);
        repeat (3) cyc();
        adc = 14'sd8191;
        cyc();
        check("k0_max", 32'(data_o), 32'd65528);

        // k=2 ramp 1..8
        enable = 1'b0; cyc();
        decim = 2'd2; enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            adc = AW'(i);
            cyc();
            if (i == 4) check("k2_sum20", 32'(data_o), 32'd20);
            if (i == 8) check("k2_sum52", 32'(data_o), 32'd52);
        end

        // Drop on busy, clear, then drop and clear together
        enable = 1'b0; cyc();
        decim = 2'd3; adc = AW'($urandom); enable = 1'b1; busy = 1'b1;
        repeat (8) cyc();
        check("drop_ovr", 32'(overrun_o), 32'd1);
        check("drop_data", 32'(data_o), 32'd52);
        busy = 1'b0; clear = 1'b1; cyc(); clear = 1'b0;
        check("clear_ovr", 32'(overrun_o), 32'd0);
        repeat (6) cyc();
        busy = 1'b1; clear = 1'b1; cyc();
        check("set_wins", 32'(overrun_o), 32'd1);
        busy = 1'b0; clear = 1'b0; cyc();
        clear = 1'b1; cyc(); clear = 1'b0;

        // Ratio change mid-block takes effect at the next block start
        enable = 1'b0; cyc();
        decim = 2'd3; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) decim = 2'd1;
            adc = AW'($urandom);
            cyc();
        end

        // Reset in the middle of a block
        decim = 2'd3;
        repeat (5) begin adc = AW'($urandom); cyc(); end
        rst = 1'b1; repeat (2) cyc();
        check("mid_rst_data", 32'(data_o), 32'd0);
        rst = 1'b0;
        repeat (10) begin adc = AW'($urandom); cyc(); end

        // Enable dropped on the block-end cycle
        enable = 1'b0; cyc();
        enable = 1'b1; repeat (7) cyc();
        enable = 1'b0; cyc();
        check("en_low_end", 32'(data_valid_o), 32'd0);
        enable = 1'b1; repeat (9) cyc();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            adc    = AW'($urandom);
            decim  = KW'($urandom_range(0, 3));
            busy   = ($urandom_range(0, 4) == 0);
            clear  = ($urandom_range(0, 19) == 0);
            enable = ($urandom_range(0, 31) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decimating_sample_feeder.md
# decimating_sample_feeder

Source-side front end for the biquad filter chain. It accumulates a free-running stream of signed ADC samples in blocks of 2^k, 1 ≤ 2^k ≤ 2^MAX_DECIM_LOG2, and emits one sum-decimated sample per block on a single-cycle `data_valid_o` strobe. It respects the filter's `busy_i` back-pressure and flags dropped samples. Its outputs connect directly to a filter's `data_i` / `data_valid_i` / `busy_o`.

## Interface
- `ADC_WIDTH`, 14, width of signed ADC input sample
- `MAX_DECIM_LOG2`, 3, largest supported log2 decimation ratio
- `OUTPUT_WIDTH`, 17, output width; must equal `ADC_WIDTH + MAX_DECIM_LOG2`

- `clk_i`  in  1  sole clock; the block uses one clock
- `rst_i`  in  1  reset, synchronous and active-high
- `enable_i`  in  1  run enable; low holds the block idle
- `decim_log2_i`  in  $clog2(MAX_DECIM_LOG2+1)  requested k; values above `MAX_DECIM_LOG2` saturate to `MAX_DECIM_LOG2`
- `adc_i`  in  ADC_WIDTH  signed sample, valid every cycle
- `busy_i`  in  1  downstream busy; a strobe is not accepted while high
- `clear_i`  in  1  clears overrun status
- `data_o`  out  OUTPUT_WIDTH  signed decimated sample
- `data_valid_o`  out  1  one-cycle strobe, new `data_o`
- `overrun_o`  out  1  sticky: a block was dropped due to `busy_i`

## Operation
- Registers: `phase_cnt` (MAX_DECIM_LOG2 bits), accumulator `acc` (OUTPUT_WIDTH bits, signed), latched ratio `k_lat`.
- States:
  - IDLE: `enable_i` low. `phase_cnt`=0, `acc`=0, no strobes.
  - RUN: `enable_i` high.
- Transitions:
  - IDLE→RUN when `enable_i` rises. The first sample is taken that cycle.
  - RUN→IDLE when `enable_i` falls. The partial block is discarded and no strobe is issued.
- Block start occurs when `phase_cnt`=0:
  - `k_lat` ← saturated `decim_log2_i`.
  - `acc` ← sign-extended `adc_i`.
- Other RUN cycles: `acc` ← `acc` + sign-extended `adc_i`. `phase_cnt` increments each cycle.
- Block end occurs on the cycle where `phase_cnt` = 2^k_lat − 1. The completed sum S includes that cycle's sample.
  - `phase_cnt` wraps to 0.
  - Candidate output = S << (MAX_DECIM_LOG2 − k_lat), so full scale is independent of k.
  - If `busy_i`=0 on that cycle, `data_o` ← candidate and `data_valid_o` pulses next cycle.
  - If `busy_i`=1, the sample is dropped, `overrun_o` ← 1, and `data_o` keeps its old value.
- Arithmetic is two's complement throughout.
  - Overflow is impossible: with 2^MAX_DECIM_LOG2 samples of −2^(ADC_WIDTH−1), S = −2^(OUTPUT_WIDTH−1).
- A change of `decim_log2_i` mid-block takes effect only at the next block start.
- `clear_i` clears `overrun_o`. If a drop and `clear_i` occur in the same cycle, the set wins.
- `data_o` holds its value between strobes.

## Timing
- Reset values:
  - `data_o`=0, `data_valid_o`=0, `overrun_o`=0.
  - `phase_cnt`=0, `acc`=0, `k_lat`=0.
- Reset is synchronous. If asserted mid-block, the block is discarded with no strobe, and the first block after release starts on the first enabled cycle.
- Latency: `data_valid_o` is high exactly one cycle after the block's last sample cycle and lasts 1 cycle.
- Strobe spacing is 2^k_lat cycles in steady state. Sustaining that rate with k < 3 is the integrator's responsibility; this block only drops on `busy_i`.
- `busy_i` is sampled only on block-end cycles.
- `enable_i` low on a block-end cycle counts as leaving RUN: no strobe.

## Configuration
- `FEEDER_OVERRUN_CNT_EN`:
  - When defined, adds output `overrun_cnt_o` [15:0]: count of dropped blocks.
  - The counter saturates at 16'hFFFF, resets to 0, and clears on `clear_i`. Same-cycle drop and clear gives 1.
  - When undefined, the port and counter are absent, and only the sticky `overrun_o` exists.

## Test plan
- k=3, `adc_i`=100 constant, `busy_i`=0: `data_valid_o` every 8 cycles, first strobe 8 cycles after enable (1 cycle after the 8th sample), `data_o`=800.
- k=0, `adc_i`=−8192: strobe every cycle, `data_o`=−65536 (17'h10000). k=0, `adc_i`=8191 gives `data_o`=65528.
- k=2, samples 1,2,3,4: `data_o`=20. The next block (5,6,7,8) gives `data_o`=52.
- k=3, `busy_i`=1 on the block-end cycle:
  - No strobe, `data_o` unchanged, `overrun_o`=1.
  - `clear_i` pulse clears it.
  - With the macro, `overrun_cnt_o` goes 0→1→0.
- `decim_log2_i` switched 3→1 at `phase_cnt`=4: the current 8-sample block completes normally, then strobes every 2 cycles with `data_o` = sum<<2.
- `rst_i` pulsed at `phase_cnt`=5, then released: no strobe for the aborted block. All outputs are 0 during reset, and the next strobe arrives 8 cycles after release.
